// File: rtl/crc_form_mc.sv
// Multi-channel packet former: moves N_BUF words from the first ready FIFO into the TX RAM and accumulates a half-word checksum.
// Optional macro CRC_FORM_MC_SEQ_EN adds a packet sequence number output that also seeds the checksum.
module crc_form_mc #(
  parameter int N_CH      = 2,
  parameter int DW        = 32,
  parameter int N_BUF     = 360,
  parameter int AW        = 11,
  parameter int UW        = 9,
  parameter int AF_THR    = 300,
  parameter int BURST_MAX = 50,
  parameter int PAUSE_CYC = 20000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*DW-1:0] fifo_q,
  input  logic [N_CH*UW-1:0] fifo_usedw,
  input  logic [N_CH-1:0]   fifo_empty,
  input  logic [N_CH-1:0]   fifo_full,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              burst_lim_en,
  input  logic              end_tx,
  output logic [N_CH-1:0]   rdreq,
  output logic [N_CH-1:0]   fifo_clr,
  output logic [DW-1:0]     q_ram,
  output logic [AW-1:0]     adr_ram,
  output logic              we_ram,
  output logic [31:0]       crc_buf,
  output logic [15:0]       nbuf,
  output logic [7:0]        channel,
`ifdef CRC_FORM_MC_SEQ_EN
  output logic [15:0]       pkt_seq,
`endif
  output logic              start,
  output logic              busy
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX + 1) : 1;
  localparam int TW = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;
  localparam logic [AW-1:0] LAST_IDX   = AW'(N_BUF - 1);
  localparam logic [TW-1:0] TMR_LAST   = TW'(PAUSE_CYC - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  localparam logic [UW-1:0] AF_THR_U   = UW'(AF_THR);

  typedef enum logic [2:0] {SELECT, RD_REQ, RD_CAP, DONE, WAIT_TX, PAUSE} state_t;

  state_t          state;
  logic [CW-1:0]   rr;
  logic [CW-1:0]   chan;
  logic [AW-1:0]   widx;
  logic [31:0]     crc;
  logic [31:0]     crc_seed;
  logic [BW-1:0]   bcnt;
  logic [TW-1:0]   tmr;
  logic            rst_p1;
  logic [N_CH-1:0] full_p1;

  logic [N_CH-1:0] cand;
  logic            found;
  logic [CW-1:0]   pick;
  logic [CW-1:0]   idx;
  logic [DW-1:0]   q_k;
  logic            empty_k;
  logic            full_k;

  function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [DW-1:0] w);
    logic [DW/2-1:0] hi;
    logic [DW/2-1:0] lo;
    hi = w[DW-1:DW/2];
    lo = w[DW/2-1:0];
    return acc + 32'(hi) + 32'(lo);
  endfunction

`ifdef CRC_FORM_MC_SEQ_EN
  assign crc_seed = {16'h0, pkt_seq};
`else
  assign crc_seed = '0;
`endif

  assign q_k     = fifo_q[int'(chan)*DW +: DW];
  assign empty_k = fifo_empty[chan];
  assign full_k  = fifo_full[chan];

  // A full FIFO is flushed while full and for one more cycle; reset flushes everything.
  assign fifo_clr = {N_CH{rst | rst_p1}} | fifo_full | full_p1;
  assign busy     = (state != SELECT) && (state != PAUSE);
  assign nbuf     = 16'(N_BUF * (DW / 8));

  always_comb begin
    cand = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand[k] = ch_en[k] && (fifo_usedw[k*UW +: UW] > AF_THR_U) && !fifo_full[k];
    end
  end

  // Round-robin search starting just after the last served channel.
  always_comb begin
    found = 1'b0;
    pick  = rr;
    idx   = rr;
    for (int i = 1; i <= N_CH; i++) begin
      idx = CW'((int'(rr) + i) % N_CH);
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Read strobe is combinational so the FIFO data is valid during RD_CAP.
  always_comb begin
    rdreq = '0;
    if (state == RD_REQ && !empty_k && !full_k) begin
      rdreq[chan] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SELECT;
      rr      <= CW'(N_CH - 1);
      chan    <= '0;
      widx    <= '0;
      crc     <= '0;
      crc_buf <= '0;
      channel <= '0;
      adr_ram <= '1;
      q_ram   <= '0;
      we_ram  <= 1'b0;
      start   <= 1'b0;
      bcnt    <= '0;
      tmr     <= '0;
      rst_p1  <= 1'b1;
      full_p1 <= '0;
`ifdef CRC_FORM_MC_SEQ_EN
      pkt_seq <= '0;
`endif
    end else begin
      rst_p1  <= 1'b0;
      full_p1 <= fifo_full;
      we_ram  <= 1'b0;
      start   <= 1'b0;
      case (state)
        SELECT: begin
          if (found) begin
            chan    <= pick;
            rr      <= pick;
            channel <= 8'(pick);
            widx    <= '0;
            crc     <= crc_seed;
            state   <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (full_k) begin
            crc     <= '0;
            adr_ram <= '1;
            state   <= SELECT;
          end else if (!empty_k) begin
            state <= RD_CAP;
          end
        end
        RD_CAP: begin
          if (full_k) begin
            crc     <= '0;
            adr_ram <= '1;
            state   <= SELECT;
          end else begin
            q_ram   <= q_k;
            we_ram  <= 1'b1;
            adr_ram <= widx;
            crc     <= csum_add(crc, q_k);
            if (widx == LAST_IDX) begin
              state <= DONE;
            end else begin
              widx  <= widx + AW'(1);
              state <= RD_REQ;
            end
          end
        end
        DONE: begin
          crc_buf <= crc;
          start   <= 1'b1;
`ifdef CRC_FORM_MC_SEQ_EN
          pkt_seq <= pkt_seq + 16'd1;
`endif
          state   <= WAIT_TX;
        end
        WAIT_TX: begin
          if (end_tx) begin
            if (burst_lim_en && bcnt == BURST_LAST) begin
              bcnt  <= '0;
              tmr   <= '0;
              state <= PAUSE;
            end else begin
              if (burst_lim_en) begin
                bcnt <= bcnt + BW'(1);
              end
              state <= SELECT;
            end
          end
        end
        PAUSE: begin
          if (tmr == TMR_LAST) begin
            state <= SELECT;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: state <= SELECT;
      endcase
    end
  end

endmodule

// File: doc/crc_form_mc.md
Name: crc_form_mc

Overview:
- Parametrised multi-channel successor to the two-channel packet former.
- Serves N_CH input FIFOs round-robin. Once a FIFO passes its almost-full threshold, the block moves N_BUF words from it into the TX buffer RAM and accumulates a 32-bit half-word checksum.
- After the last word it pulses start to the transmitter, then waits for end_tx.
- Sits between the ADC/packet FIFOs and the Ethernet/UDP TX engine, with burst limiting and an inter-burst pause.

Parameters:
- N_CH, 2, number of input channels (1..8)
- DW, 32, FIFO/RAM data width (even)
- N_BUF, 360, words per packet buffer
- AW, 11, RAM address width (2^AW >= N_BUF)
- UW, 9, FIFO usedw width
- AF_THR, 300, usedw level above which a channel is ready (strictly greater)
- BURST_MAX, 50, packets per burst before a pause
- PAUSE_CYC, 20000000, pause length in clk cycles

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- fifo_q  in  N_CH*DW  FIFO read data, channel k at [k*DW +: DW]
- fifo_usedw  in  N_CH*UW  FIFO fill levels
- fifo_empty  in  N_CH  FIFO empty flags
- fifo_full  in  N_CH  FIFO full flags
- ch_en  in  N_CH  channel enable mask
- burst_lim_en  in  1  1 = count packets and enforce the pause
- end_tx  in  1  transmitter finished current packet (1-cycle pulse)
- rdreq  out  N_CH  FIFO read strobes
- fifo_clr  out  N_CH  per-channel FIFO flush
- q_ram  out  DW  RAM write data
- adr_ram  out  AW  RAM write address
- we_ram  out  1  RAM write enable
- crc_buf  out  32  checksum of the finished packet
- nbuf  out  16  constant N_BUF*(DW/8), packet length in bytes
- channel  out  8  channel of the current or last packet
- start  out  1  1-cycle packet-ready pulse
- busy  out  1  high in every state except SELECT and PAUSE

Behaviour:
- Reset (rst=1):
  - State goes to SELECT; rr pointer = N_CH-1, so channel 0 is checked first.
  - Outputs: rdreq=0, we_ram=0, start=0, crc_buf=0, channel=0, adr_ram=all ones, q_ram=0.
  - Burst counter = 0, pause timer = 0.
  - fifo_clr = all ones while rst and for the first cycle after rst falls, then 0.
- SELECT:
  - Search order is rr+1, rr+2, ... modulo N_CH.
  - Pick the first channel k with ch_en[k]=1, usedw_k>AF_THR and fifo_full[k]=0.
  - On a pick: channel<=k, rr<=k, address counter and checksum cleared, go to RD_REQ.
  - No candidate: stay in SELECT.
- RD_REQ:
  - If fifo_empty[k]=0: rdreq[k]=1 for exactly one cycle, go to RD_CAP.
  - If empty: stall with rdreq=0.
- RD_CAP (the cycle after rdreq):
  - q_ram<=fifo_q_k, we_ram<=1 for one cycle, adr_ram<=word index (0..N_BUF-1).
  - crc <= crc + q[DW-1:DW/2] + q[DW/2-1:0], zero-extended, modulo 2^32.
  - If index = N_BUF-1, go to DONE; otherwise go to RD_REQ.
  - Throughput is one word per 2 cycles.
- DONE: crc_buf<=crc, start=1 for one cycle, go to WAIT_TX.
- WAIT_TX:
  - On end_tx: if burst_lim_en, increment the burst counter.
  - If the counter reaches BURST_MAX: counter<=0, go to PAUSE; otherwise go to SELECT.
  - end_tx in any other state is ignored.
- PAUSE:
  - Count PAUSE_CYC cycles, then return to SELECT.
  - fifo_full handling stays active during PAUSE.
- Full handling, any state, per channel:
  - fifo_full[j]=1 asserts fifo_clr[j] while full, plus one cycle.
  - If j is the active channel in RD_REQ/RD_CAP: abort. No start is issued, the checksum is cleared, adr_ram goes to all ones, and the state returns to SELECT. rr advances past j.
  - Full in DONE/WAIT_TX does not affect the packet already formed.
- Simultaneous events:
  - A full on a non-active channel does not disturb the active transfer.
  - end_tx together with a fifo_full is handled as both events.
- burst_lim_en=0: the burst counter holds its value and PAUSE is never entered.

Optional Feature:
- Macro: CRC_FORM_MC_SEQ_EN.
- Defined:
  - Adds output pkt_seq[15:0]: a global packet sequence number, reset 0, incremented in DONE.
  - The checksum seed for each packet is {16'h0, pkt_seq} instead of 0.
  - crc_buf therefore covers the sequence number.
- Undefined: port absent, checksum seed 0.

Test Plan:
- N_CH=2, N_BUF=4, ch0 usedw=301, data 0x00010002, 0x00030004, 0x00050006, 0x00070008:
  - expect 4 rdreq[0] pulses, adr 0..3 with we_ram;
  - expect crc_buf=0x00000024, start pulse, channel=0.
- Both channels usedw=400, repeated end_tx: packets alternate 0,1,0,1; ch_en=2'b01 gives only channel 0.
- fifo_full[0] after 2 words of a packet: fifo_clr[0] pulses, no start, adr_ram=all ones, next packet begins at adr 0.
- burst_lim_en=1, BURST_MAX=3, PAUSE_CYC=100: after the 3rd end_tx, no rdreq for exactly 100 cycles.
- fifo_empty toggles mid-packet: rdreq is held off while empty, and the word order and crc are unchanged.
- rst asserted in RD_CAP: all outputs return to reset values, fifo_clr=all ones for one cycle after release; with SEQ_EN, pkt_seq=0 and the first crc seed is 0.
